// File: rtl/prio_irq_pkg.sv
// Shared definitions for the priority interrupt controller: sizes and FSM state type.
package prio_irq_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned ID_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage : prio_irq_pkg

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder: reports the index of the highest set bit.
// Ports:
//   vec_i  - input vector, bit NUM_REQ-1 has highest priority
//   idx_c  - index of the highest set bit (0 when vec_i is zero)
//   any_c  - 1 when any bit of vec_i is set
module prio_enc8
    import prio_irq_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec_i,
    output logic [ID_W-1:0]    idx_c,
    output logic               any_c
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        idx_c = '0;
        any_c = |vec_i;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (vec_i[i]) begin
                idx_c = ID_W'(i);
            end
        end
    end

endmodule : prio_enc8

// File: rtl/priority_irq_ctrl.sv
// Priority interrupt controller: captures request lines into a pending register and
// offers the highest-priority unmasked pending line through a valid/ready handshake.
// Optional build macro: PRIO_IRQ_OVF_EN enables the sticky overflow flag
// (undefined: ovf is tied to 0).
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   req        - request lines, bit 7 highest priority
//   mask       - 1 excludes a line from grant selection (it can still become pending)
//   en         - 1 allows new grants to be issued
//   out_ready  - consumer accepts the offered grant
//   out_valid  - grant offered
//   out_id     - index of the granted line
//   pending    - current pending register
//   ovf        - sticky overflow flag
module priority_irq_ctrl
    import prio_irq_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               en,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id,
    output logic [NUM_REQ-1:0] pending,
    output logic               ovf
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] cap_c;
    logic [NUM_REQ-1:0] clr_c;
    logic [NUM_REQ-1:0] elig_c;
    logic [ID_W-1:0]    enc_idx_c;
    logic               enc_any_c;
    logic               hs_c;

    // Capture term: rising edge or level, depending on EDGE_MODE.
    assign cap_c  = (EDGE_MODE != 0) ? (req & ~req_q) : req;

    // Handshake clears the granted line; a same-cycle capture re-sets it.
    assign hs_c      = (state_q == OFFER) && out_ready;
    assign clr_c     = hs_c ? (NUM_REQ'(1) << out_id_q) : '0;
    assign pending_d = (pending_q & ~clr_c) | cap_c;

    assign elig_c = pending_q & ~mask;

    prio_enc8 u_enc (
        .vec_i (elig_c),
        .idx_c (enc_idx_c),
        .any_c (enc_any_c)
    );

    // FSM state and grant id register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            out_id_q <= '0;
        end else begin
            state_q  <= state_d;
            out_id_q <= out_id_d;
        end
    end

    // Next-state: every grant returns through IDLE, so the id is frozen during OFFER.
    always_comb begin
        state_d  = state_q;
        out_id_d = out_id_q;
        unique case (state_q)
            IDLE: begin
                if (en && enc_any_c) begin
                    state_d  = OFFER;
                    out_id_d = enc_idx_c;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending register and request history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            req_q     <= '0;
        end else begin
            pending_q <= pending_d;
            req_q     <= req;
        end
    end

`ifdef PRIO_IRQ_OVF_EN
    logic ovf_q;

    // Sticky: a capture on a line that is already pending and not being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (|(cap_c & pending_q & ~clr_c)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = (state_q == OFFER);
    assign out_id    = out_id_q;
    assign pending   = pending_q;

endmodule : priority_irq_ctrl

// File: doc/priority_irq_ctrl.md
PRIORITY_IRQ_CTRL -- requirements
Module: priority_irq_ctrl

Interface
REQ-001 Parameter: EDGE_MODE, default 1, 1 = capture rising edges of req, 0 = capture level-high req.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: req  in  8  request lines; bit 7 is highest priority, bit 0 is lowest.
REQ-005 Port: mask  in  8  1 = line masked from grant selection; a masked line can still become pending.
REQ-006 Port: en  in  1  1 = new grants may be issued.
REQ-007 Port: out_ready  in  1  consumer accepts the current grant.
REQ-008 Port: out_valid  out  1  grant offered.
REQ-009 Port: out_id  out  3  encoded index of the granted line; 7 for req[7], 0 for req[0].
REQ-010 Port: pending  out  8  current pending register.
REQ-011 Port: ovf  out  1  sticky overflow flag.

Function
REQ-012 Capture, EDGE_MODE=1: req_q registers req; a line's capture term is req & ~req_q.
REQ-013 Capture, EDGE_MODE=0: a line's capture term is req.
REQ-014 Pending set: a capture term sets the corresponding pending bit at the same clock edge.
REQ-015 FSM states: IDLE, OFFER.
REQ-016 IDLE -> OFFER when en=1 and (pending & ~mask) != 0.
- On this transition, out_id latches the highest set bit of (pending & ~mask).
- out_valid becomes 1 at the same edge.
REQ-017 Latency: a req rise sampled at edge k (EDGE_MODE=1) gives pending at edge k and out_valid at edge k+1, provided the controller is IDLE and en=1.
REQ-018 In OFFER, out_id and out_valid stay stable until out_valid and out_ready are both 1.
- Stability holds even if a higher-priority request arrives.
- Stability holds even if en or mask change.
REQ-019 Handshake (out_valid=1, out_ready=1): clear pending[out_id] and return to IDLE; out_valid is 0 on the next cycle.
REQ-020 Throughput: at most one grant every 2 cycles, because each grant passes through IDLE.
REQ-021 Simultaneous clear and capture on the same line: capture wins, so the bit stays pending.
REQ-022 en=0: no new grants are issued; an OFFER in progress still completes on handshake; capture continues.
REQ-023 All pending bits masked: stay in IDLE; out_id holds its last value.
REQ-024 out_id in IDLE is don't-care to consumers, but is not X; it is held.

Reset
REQ-025 rst=1 at a clock edge sets:
- FSM to IDLE;
- pending, req_q, out_id, out_valid and ovf to 0.
REQ-026 rst asserted mid-OFFER aborts the grant; out_valid is 0 at the following edge and no pending bit survives.
REQ-027 First cycle after reset, EDGE_MODE=1: req_q=0, so a req held high through reset captures once.

Configuration
REQ-028 Macro PRIO_IRQ_OVF_EN.
- Defined: ovf sets when a capture term hits a line whose pending bit is already 1 and is not being cleared in that cycle. ovf clears only on rst.
- Undefined: no overflow logic is built; ovf is tied to 0; the port list is unchanged.

Structure
REQ-029 Package prio_irq_pkg holds:
- NUM_REQ=8 and ID_W=3;
- the FSM state typedef (IDLE, OFFER).
REQ-030 Sub-module prio_enc8: combinational 8-to-3 highest-bit encoder with an any-set flag, instanced once on pending & ~mask.

Verification
REQ-031 Reset, then req=8'h01 for one cycle, out_ready=1, en=1, mask=0 -> out_valid at edge k+1 with out_id=0; pending returns to 0 after the handshake.
REQ-032 req=8'h81 in the same cycle, out_ready=1 -> grants id 7, then id 0 two cycles later; pending=0 at the end.
REQ-033 Grant id 2 offered with out_ready=0, then req[6] rises -> out_id stays 2 until ready; id 6 is granted next.
REQ-034 mask=8'h80, req=8'h80 -> no out_valid, pending=8'h80; clearing mask -> out_id=7 on the next edge.
REQ-035 Re-edge on req[3] while pending[3]=1, with PRIO_IRQ_OVF_EN defined -> ovf=1 until rst; with the macro undefined -> ovf stays 0.
REQ-036 rst pulse while out_valid=1 and out_ready=0 -> out_valid=0 and pending=0 the next cycle; EDGE_MODE=0 with req[5] held high -> id 5 is re-granted every 2 cycles.
